dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-requester arbiter and access sequencer in front of the single-port `data_memory`. It serves the core load/store unit (port 0) and the program loader/DMA (port 1) with round-robin fairness. It drives the memory's address, write-data and write-enable, which are written on the falling edge and read combinationally. It also implements byte-enabled stores as read-modify-write sequences.

## Interface
- ADDRESS_WIDTH, 32, byte-address width of requesters and memory word-index width
- DATA_WIDTH, 32, memory word width; multiple of 8; byte-enable width BW = DATA_WIDTH/8
- CLK  in  1  clock; all state changes on rising edge
- RST_N  in  1  asynchronous, active-low reset
- REQ0, REQ1  in  1  access request; held high until the matching GNT
- WE0, WE1  in  1  1 = write, 0 = read
- A0, A1  in  ADDRESS_WIDTH  byte address; bits [1:0] ignored
- WD0, WD1  in  DATA_WIDTH  write data, byte lanes aligned to word
- BE0, BE1  in  BW  byte enables for writes; ignored for reads
- GNT0, GNT1  out  1  request accepted this cycle (combinational)
- DONE0, DONE1  out  1  one-cycle completion pulse
- RDATA0, RDATA1  out  DATA_WIDTH  read data; valid when DONE is high for a read
- MEM_A  out  ADDRESS_WIDTH  word index to memory = latched A >> 2
- MEM_WD  out  DATA_WIDTH  memory write data
- MEM_WE  out  1  memory write enable
- MEM_RD  in  DATA_WIDTH  memory read data (combinational from MEM_A)

## Operation
- FSM states: IDLE, ACCESS, MERGE.
- IDLE:
  - If any REQ is high, select a winner and assert its GNT combinationally.
  - At the rising edge, latch owner, WE, A, WD and BE, then go to ACCESS.
  - GNT is never asserted outside IDLE or while RST_N is low.
- Arbitration:
  - Only one requester: it wins.
  - Both requesters: the port not granted most recently wins.
  - The LAST pointer updates at every grant. The reset value of LAST is 1, so port 0 wins the first tie.
- ACCESS:
  - MEM_A = latched word index.
  - Read: MEM_WE = 0. MEM_RD is captured into the owner's RDATA at the rising edge. Next state IDLE.
  - Write with BE all ones: MEM_WE = 1 and MEM_WD = WD, so the memory writes at the falling edge. Next state IDLE.
  - Write with BE all zeros: no memory write (MEM_WE = 0). Next state IDLE; completes as a normal write.
  - Partial write (any other BE): MEM_WE = 0. MEM_RD is captured into an internal old-word register. Next state MERGE.
- MERGE:
  - MEM_A is held.
  - MEM_WE = 1.
  - MEM_WD byte i = WD byte i when BE[i] = 1, otherwise old-word byte i.
  - Next state IDLE.
- Completion:
  - The owner's DONE is registered high for exactly the cycle following the last ACCESS or MERGE cycle. That cycle is also IDLE, so a new grant can coincide with DONE.
  - RDATA of a port changes only on that port's reads. It holds its value otherwise, including across writes.
- A requester deasserting REQ without a GNT is legal and simply withdraws the request. Request fields after GNT are don't-care.

## Timing
- Reset (async assert) drives: state IDLE, LAST = 1, DONE0/1 = 0, RDATA0/1 = 0, MEM_WE = 0, MEM_A = 0, MEM_WD = 0, GNT0/1 = 0.
- Reset mid-operation: an in-flight access is abandoned with no DONE. MEM_WE falls immediately, so an aborted MERGE performs no write.
- MEM_A, MEM_WD and MEM_WE derive only from flops. They are stable from shortly after the rising edge through the falling-edge write.
- Latency from the grant cycle to DONE:
  - Read or full/empty-BE write: DONE 2 cycles later.
  - Partial write: DONE 3 cycles later.
- Throughput: one access per 2 cycles (read/full write) or per 3 cycles (partial write).
- Ports are served in strict alternation under continuous contention. A port never waits behind more than one access of the other port.
- Read-after-write to the same address by either port returns the new data. The write completes before the next grant can issue.

## Test plan
- Reset, then REQ0 read of A0=0x10 with mem[4]=0xDEADBEEF -> GNT0 in cycle 0; MEM_A=4 in cycle 1; DONE0 and RDATA0=0xDEADBEEF in cycle 2; GNT1, DONE1 and MEM_WE stay 0 throughout.
- REQ1 write A1=0x20, WD1=0x12345678, BE1=4'hF -> MEM_WE=1 for exactly one cycle with MEM_WD=0x12345678 and MEM_A=8; DONE1 one cycle later; a following read of 0x20 returns 0x12345678.
- mem[3]=0xAABBCCDD, REQ0 write A0=0x0C, WD0=0x11223344, BE0=4'b0101 -> ACCESS with MEM_WE=0, then MERGE with MEM_WE=1 and MEM_WD=0xAA22CC44; DONE0 three cycles after the grant.
- REQ0 and REQ1 both held high continuously after reset -> grants alternate 0,1,0,1 every 2 cycles; each DONE pulses one cycle after its access and overlaps the next grant.
- Write with BE=4'h0 -> MEM_WE never asserted; DONE pulses 2 cycles after the grant; memory contents unchanged.
- RST_N pulled low during the MERGE cycle -> MEM_WE drops to 0 immediately; no DONE; target word unchanged; after release, the first tie grants port 0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and access sequencer for two requesters sharing a single-port data memory.
// DONE follows the grant by 2 cycles (read, full or empty write) or 3 (partial write); GNT only in IDLE.
module dmem_arbiter #(
   parameter int ADDRESS_WIDTH = 32,
   parameter int DATA_WIDTH    = 32
) (
   input  logic                       CLK,
   input  logic                       RST_N,
   input  logic                       REQ0,
   input  logic                       REQ1,
   input  logic                       WE0,
   input  logic                       WE1,
   input  logic [ADDRESS_WIDTH-1:0]   A0,
   input  logic [ADDRESS_WIDTH-1:0]   A1,
   input  logic [DATA_WIDTH-1:0]      WD0,
   input  logic [DATA_WIDTH-1:0]      WD1,
   input  logic [DATA_WIDTH/8-1:0]    BE0,
   input  logic [DATA_WIDTH/8-1:0]    BE1,
   output logic                       GNT0,
   output logic                       GNT1,
   output logic                       DONE0,
   output logic                       DONE1,
   output logic [DATA_WIDTH-1:0]      RDATA0,
   output logic [DATA_WIDTH-1:0]      RDATA1,
   output logic [ADDRESS_WIDTH-1:0]   MEM_A,
   output logic [DATA_WIDTH-1:0]      MEM_WD,
   output logic                       MEM_WE,
   input  logic [DATA_WIDTH-1:0]      MEM_RD
);

   localparam int BW = DATA_WIDTH / 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      MERGE  = 2'd2
   } state_t;

   state_t                     state_q, state_d;
   logic                       owner_q, owner_d;
   logic                       we_q, we_d;
   logic [ADDRESS_WIDTH-1:0]   addr_q, addr_d;
   logic [DATA_WIDTH-1:0]      wd_q, wd_d;
   logic [BW-1:0]              be_q, be_d;
   logic [DATA_WIDTH-1:0]      old_q, old_d;
   logic                       last_q, last_d;
   logic [1:0]                 done_q, done_d;
   logic [DATA_WIDTH-1:0]      rdata0_q, rdata0_d;
   logic [DATA_WIDTH-1:0]      rdata1_q, rdata1_d;

   logic                       grant_vld;
   logic                       win;
   logic                       be_full;
   logic                       be_none;
   logic                       partial;
   logic                       unused_addr_lsbs;

   // Low address bits select a byte within the word and play no part in word access.
   assign unused_addr_lsbs = ^{A0[1:0], A1[1:0]};

   // Tie goes to the port that did not win last; a lone requester always wins.
   always_comb begin
      win = 1'b0;
      if (REQ0 && REQ1) begin
         win = ~last_q;
      end else if (REQ1) begin
         win = 1'b1;
      end
   end

   assign grant_vld = (state_q == IDLE) && (REQ0 || REQ1) && RST_N;
   assign be_full   = &be_q;
   assign be_none   = ~|be_q;
   assign partial   = we_q && !be_full && !be_none;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (grant_vld) begin
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            state_d = partial ? MERGE : IDLE;
         end
         MERGE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      GNT0   = grant_vld && !win;
      GNT1   = grant_vld && win;
      MEM_A  = addr_q;
      MEM_WE = 1'b0;
      MEM_WD = wd_q;
      case (state_q)
         ACCESS: begin
            MEM_WE = we_q && be_full;
         end
         MERGE: begin
            MEM_WE = 1'b1;
            for (int i = 0; i < BW; i++) begin
               MEM_WD[i*8 +: 8] = be_q[i] ? wd_q[i*8 +: 8] : old_q[i*8 +: 8];
            end
         end
         default: begin
            MEM_WE = 1'b0;
         end
      endcase
   end

   always_comb begin
      owner_d  = owner_q;
      we_d     = we_q;
      addr_d   = addr_q;
      wd_d     = wd_q;
      be_d     = be_q;
      old_d    = old_q;
      last_d   = last_q;
      done_d   = 2'b00;
      rdata0_d = rdata0_q;
      rdata1_d = rdata1_q;

      if (grant_vld) begin
         owner_d = win;
         last_d  = win;
         if (win) begin
            we_d   = WE1;
            addr_d = {2'b00, A1[ADDRESS_WIDTH-1:2]};
            wd_d   = WD1;
            be_d   = BE1;
         end else begin
            we_d   = WE0;
            addr_d = {2'b00, A0[ADDRESS_WIDTH-1:2]};
            wd_d   = WD0;
            be_d   = BE0;
         end
      end

      if (state_q == ACCESS) begin
         if (!we_q) begin
            if (owner_q) begin
               rdata1_d = MEM_RD;
            end else begin
               rdata0_d = MEM_RD;
            end
         end
         if (partial) begin
            old_d = MEM_RD;
         end
      end

      // DONE lands in the IDLE cycle after the final memory cycle of the access.
      if ((state_q == ACCESS && !partial) || state_q == MERGE) begin
         done_d[owner_q] = 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         owner_q  <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wd_q     <= '0;
         be_q     <= '0;
         old_q    <= '0;
         last_q   <= 1'b1;
         done_q   <= 2'b00;
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else begin
         owner_q  <= owner_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wd_q     <= wd_d;
         be_q     <= be_d;
         old_q    <= old_d;
         last_q   <= last_d;
         done_q   <= done_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
      end
   end

   assign DONE0  = done_q[0];
   assign DONE1  = done_q[1];
   assign RDATA0 = rdata0_q;
   assign RDATA1 = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a falling-edge-write memory model.
module tb_dmem_arbiter;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b1;
   logic        REQ0 = 1'b0, REQ1 = 1'b0, WE0 = 1'b0, WE1 = 1'b0;
   logic [31:0] A0 = '0, A1 = '0, WD0 = '0, WD1 = '0;
   logic [3:0]  BE0 = '0, BE1 = '0;
   logic        GNT0, GNT1, DONE0, DONE1, MEM_WE;
   logic [31:0] RDATA0, RDATA1, MEM_A, MEM_WD, MEM_RD;

   logic [31:0] mem [0:255];
   logic        pre_vld = 1'b0;
   logic [7:0]  pre_addr = '0;
   logic [31:0] pre_dat = '0;

   int checks = 0;
   int failures = 0;

   dmem_arbiter #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) dut (
      .CLK(CLK), .RST_N(RST_N),
      .REQ0(REQ0), .REQ1(REQ1), .WE0(WE0), .WE1(WE1),
      .A0(A0), .A1(A1), .WD0(WD0), .WD1(WD1), .BE0(BE0), .BE1(BE1),
      .GNT0(GNT0), .GNT1(GNT1), .DONE0(DONE0), .DONE1(DONE1),
      .RDATA0(RDATA0), .RDATA1(RDATA1),
      .MEM_A(MEM_A), .MEM_WD(MEM_WD), .MEM_WE(MEM_WE), .MEM_RD(MEM_RD)
   );

   always #5 CLK = ~CLK;

   always @(negedge CLK) begin
      if (MEM_WE) mem[MEM_A[7:0]] <= MEM_WD;
      else if (pre_vld) mem[pre_addr] <= pre_dat;
   end
   assign MEM_RD = mem[MEM_A[7:0]];

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   task automatic preload(input logic [7:0] a, input logic [31:0] d);
      pre_addr = a;
      pre_dat  = d;
      pre_vld  = 1'b1;
      @(negedge CLK);
      #1;
      pre_vld  = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      RST_N = 1'b0;
      REQ0 = 1'b1;
      #1;
      checks++; if (GNT0 !== 1'b0) begin failures++; $display("FAIL rst_gnt0 got=%b exp=0", GNT0); end
      checks++; if (DONE0 !== 1'b0 || DONE1 !== 1'b0) begin failures++; $display("FAIL rst_done got=%b%b exp=00", DONE1, DONE0); end
      checks++; if (MEM_WE !== 1'b0) begin failures++; $display("FAIL rst_mem_we got=%b exp=0", MEM_WE); end
      checks++; if (MEM_A !== 32'h0 || MEM_WD !== 32'h0) begin failures++; $display("FAIL rst_mem_bus got=%h/%h exp=0/0", MEM_A, MEM_WD); end
      checks++; if (RDATA0 !== 32'h0 || RDATA1 !== 32'h0) begin failures++; $display("FAIL rst_rdata got=%h/%h exp=0/0", RDATA0, RDATA1); end
      cyc();
      REQ0 = 1'b0;
      RST_N = 1'b1;
   endtask

   task automatic test_read();
      preload(8'd4, 32'hDEADBEEF);
      cyc();
      REQ0 = 1'b1; WE0 = 1'b0; A0 = 32'h10;
      #1;
      checks++; if (GNT0 !== 1'b1 || GNT1 !== 1'b0) begin failures++; $display("FAIL rd_gnt got=%b%b exp=01", GNT1, GNT0); end
      cyc();
      REQ0 = 1'b0;
      checks++; if (MEM_A !== 32'd4) begin failures++; $display("FAIL rd_mem_a got=%h exp=4", MEM_A); end
      checks++; if (MEM_WE !== 1'b0 || DONE0 !== 1'b0 || GNT0 !== 1'b0) begin failures++; $display("FAIL rd_access we=%b done0=%b gnt0=%b exp=000", MEM_WE, DONE0, GNT0); end
      cyc();
      checks++; if (DONE0 !== 1'b1 || DONE1 !== 1'b0) begin failures++; $display("FAIL rd_done got=%b%b exp=01", DONE1, DONE0); end
      checks++; if (RDATA0 !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_rdata0 got=%h exp=deadbeef", RDATA0); end
      cyc();
      checks++; if (DONE0 !== 1'b0) begin failures++; $display("FAIL rd_done_pulse got=%b exp=0", DONE0); end
   endtask

   task automatic test_full_write();
      REQ1 = 1'b1; WE1 = 1'b1; A1 = 32'h20; WD1 = 32'h12345678; BE1 = 4'hF;
      #1;
      checks++; if (GNT1 !== 1'b1 || GNT0 !== 1'b0) begin failures++; $display("FAIL wr_gnt got=%b%b exp=10", GNT1, GNT0); end
      cyc();
      REQ1 = 1'b0;
      checks++; if (MEM_WE !== 1'b1 || MEM_WD !== 32'h12345678 || MEM_A !== 32'd8) begin failures++; $display("FAIL wr_access we=%b wd=%h a=%h exp=1/12345678/8", MEM_WE, MEM_WD, MEM_A); end
      checks++; if (DONE1 !== 1'b0) begin failures++; $display("FAIL wr_early_done got=%b exp=0", DONE1); end
      cyc();
      checks++; if (MEM_WE !== 1'b0 || DONE1 !== 1'b1) begin failures++; $display("FAIL wr_done we=%b done1=%b exp=0/1", MEM_WE, DONE1); end
      checks++; if (mem[8] !== 32'h12345678) begin failures++; $display("FAIL wr_mem got=%h exp=12345678", mem[8]); end
      REQ1 = 1'b1; WE1 = 1'b0; A1 = 32'h20;
      #1;
      checks++; if (GNT1 !== 1'b1) begin failures++; $display("FAIL raw_gnt1 got=%b exp=1", GNT1); end
      cyc();
      REQ1 = 1'b0;
      cyc();
      checks++; if (DONE1 !== 1'b1 || RDATA1 !== 32'h12345678) begin failures++; $display("FAIL raw_read done1=%b rdata1=%h exp=1/12345678", DONE1, RDATA1); end
      checks++; if (RDATA0 !== 32'hDEADBEEF) begin failures++; $display("FAIL raw_rdata0_hold got=%h exp=deadbeef", RDATA0); end
   endtask

   task automatic test_partial_write();
      preload(8'd3, 32'hAABBCCDD);
      cyc();
      REQ0 = 1'b1; WE0 = 1'b1; A0 = 32'h0C; WD0 = 32'h11223344; BE0 = 4'b0101;
      #1;
      checks++; if (GNT0 !== 1'b1) begin failures++; $display("FAIL pw_gnt0 got=%b exp=1", GNT0); end
      cyc();
      REQ0 = 1'b0;
      checks++; if (MEM_WE !== 1'b0 || MEM_A !== 32'd3) begin failures++; $display("FAIL pw_access we=%b a=%h exp=0/3", MEM_WE, MEM_A); end
      cyc();
      checks++; if (MEM_WE !== 1'b1 || MEM_WD !== 32'hAA22CC44 || MEM_A !== 32'd3) begin failures++; $display("FAIL pw_merge we=%b wd=%h a=%h exp=1/aa22cc44/3", MEM_WE, MEM_WD, MEM_A); end
      checks++; if (DONE0 !== 1'b0) begin failures++; $display("FAIL pw_early_done got=%b exp=0", DONE0); end
      cyc();
      checks++; if (DONE0 !== 1'b1 || MEM_WE !== 1'b0) begin failures++; $display("FAIL pw_done done0=%b we=%b exp=1/0", DONE0, MEM_WE); end
      checks++; if (mem[3] !== 32'hAA22CC44) begin failures++; $display("FAIL pw_mem got=%h exp=aa22cc44", mem[3]); end
      checks++; if (RDATA0 !== 32'hDEADBEEF) begin failures++; $display("FAIL pw_rdata0_hold got=%h exp=deadbeef", RDATA0); end
   endtask

   task automatic test_empty_be();
      preload(8'd5, 32'hCAFEF00D);
      cyc();
      REQ0 = 1'b1; WE0 = 1'b1; A0 = 32'h14; WD0 = 32'h0; BE0 = 4'h0;
      #1;
      checks++; if (GNT0 !== 1'b1) begin failures++; $display("FAIL be0_gnt0 got=%b exp=1", GNT0); end
      cyc();
      REQ0 = 1'b0;
      checks++; if (MEM_WE !== 1'b0) begin failures++; $display("FAIL be0_access_we got=%b exp=0", MEM_WE); end
      cyc();
      checks++; if (DONE0 !== 1'b1 || MEM_WE !== 1'b0) begin failures++; $display("FAIL be0_done done0=%b we=%b exp=1/0", DONE0, MEM_WE); end
      cyc();
      checks++; if (mem[5] !== 32'hCAFEF00D) begin failures++; $display("FAIL be0_mem got=%h exp=cafef00d", mem[5]); end
   endtask

   task automatic test_back_to_back();
      RST_N = 1'b0;
      REQ0 = 1'b1; WE0 = 1'b0; A0 = 32'h10;
      REQ1 = 1'b1; WE1 = 1'b0; A1 = 32'h20;
      #1;
      checks++; if (GNT0 !== 1'b0 || GNT1 !== 1'b0) begin failures++; $display("FAIL b2b_rst_gnt got=%b%b exp=00", GNT1, GNT0); end
      cyc();
      RST_N = 1'b1;
      #1;
      for (int k = 0; k < 9; k++) begin
         logic e_g0, e_g1, e_d0, e_d1;
         e_g0 = (k % 4 == 0);
         e_g1 = (k % 4 == 2);
         e_d0 = (k % 4 == 2);
         e_d1 = (k % 4 == 0) && (k > 0);
         checks++; if (GNT0 !== e_g0 || GNT1 !== e_g1) begin failures++; $display("FAIL b2b_gnt k=%0d got=%b%b exp=%b%b", k, GNT1, GNT0, e_g1, e_g0); end
         checks++; if (DONE0 !== e_d0 || DONE1 !== e_d1) begin failures++; $display("FAIL b2b_done k=%0d got=%b%b exp=%b%b", k, DONE1, DONE0, e_d1, e_d0); end
         cyc();
      end
      REQ0 = 1'b0; REQ1 = 1'b0;
      checks++; if (RDATA0 !== 32'hDEADBEEF || RDATA1 !== 32'h12345678) begin failures++; $display("FAIL b2b_rdata got=%h/%h exp=deadbeef/12345678", RDATA0, RDATA1); end
      cyc();
      cyc();
   endtask

   task automatic test_reset_in_merge();
      preload(8'd6, 32'h11111111);
      cyc();
      REQ1 = 1'b1; WE1 = 1'b1; A1 = 32'h18; WD1 = 32'hFFFFFFFF; BE1 = 4'b0011;
      #1;
      checks++; if (GNT1 !== 1'b1) begin failures++; $display("FAIL rm_gnt1 got=%b exp=1", GNT1); end
      cyc();
      REQ1 = 1'b0;
      cyc();
      checks++; if (MEM_WE !== 1'b1) begin failures++; $display("FAIL rm_merge_we got=%b exp=1", MEM_WE); end
      RST_N = 1'b0;
      #1;
      checks++; if (MEM_WE !== 1'b0) begin failures++; $display("FAIL rm_we_drop got=%b exp=0", MEM_WE); end
      cyc();
      cyc();
      checks++; if (DONE1 !== 1'b0 || DONE0 !== 1'b0) begin failures++; $display("FAIL rm_no_done got=%b%b exp=00", DONE1, DONE0); end
      checks++; if (mem[6] !== 32'h11111111) begin failures++; $display("FAIL rm_mem got=%h exp=11111111", mem[6]); end
      REQ0 = 1'b1; WE0 = 1'b0; A0 = 32'h10;
      REQ1 = 1'b1; WE1 = 1'b0; A1 = 32'h20;
      RST_N = 1'b1;
      #1;
      checks++; if (GNT0 !== 1'b1 || GNT1 !== 1'b0) begin failures++; $display("FAIL rm_tie_gnt got=%b%b exp=01", GNT1, GNT0); end
      cyc();
      REQ0 = 1'b0; REQ1 = 1'b0;
      cyc();
      cyc();
      checks++; if (DONE1 !== 1'b0 || DONE0 !== 1'b0) begin failures++; $display("FAIL rm_tail_done got=%b%b exp=00", DONE1, DONE0); end
   endtask

   initial begin
      test_reset();
      test_read();
      test_full_write();
      test_partial_write();
      test_empty_be();
      test_back_to_back();
      test_reset_in_merge();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
